// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg: shared state and grant types for the cache-to-memory arbiter
package arb_types;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;
endpackage

// File: rtl/twomux.sv
// twomux: two-input mux; select picks in1 when high
module twomux #(
  parameter int width = 1
) (
  input  logic             select,
  input  logic [width-1:0] in0,
  input  logic [width-1:0] in1,
  output logic [width-1:0] out
);
  assign out = select ? in1 : in0;
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one pmem port between I-cache and D-cache
// ARB_ROUND_ROBIN_EN selects round-robin tie-break; default gives D fixed priority
module cache_mem_arbiter
  import arb_types::*;
#(
  parameter int addr_width = 32,
  parameter int line_width = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [addr_width-1:0] i_address,
  output logic                  i_resp,
  output logic [line_width-1:0] i_rdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [addr_width-1:0] d_address,
  input  logic [line_width-1:0] d_wdata,
  output logic                  d_resp,
  output logic [line_width-1:0] d_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [addr_width-1:0] pmem_address,
  output logic [line_width-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [line_width-1:0] pmem_rdata
);
  arb_state_t state, next_state;
  logic i_pend, d_pend, pick_d, sel_d;
  assign i_pend = i_read;
  assign d_pend = d_read | d_write;
  assign sel_d  = state == SERVE_D;
`ifdef ARB_ROUND_ROBIN_EN
  grant_t last_grant;
  always_ff @(posedge clk) begin
    if (rst) last_grant <= GRANT_D;
    else if (state == IDLE && next_state != IDLE) last_grant <= next_state == SERVE_D ? GRANT_D : GRANT_I;
  end
  // on a tie, D wins only if I was granted last
  assign pick_d = d_pend && (!i_pend || last_grant == GRANT_I);
`else
  assign pick_d = d_pend;
`endif
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = state;
    if (state == IDLE) next_state = pick_d ? SERVE_D : i_pend ? SERVE_I : IDLE;
    else if (pmem_resp) next_state = IDLE;
  end
  always_comb begin
    pmem_read  = state == SERVE_I || (sel_d && d_read && !d_write);
    pmem_write = sel_d && d_write;
    i_resp     = state == SERVE_I && pmem_resp;
    d_resp     = sel_d && pmem_resp;
  end
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;
  twomux #(.width(addr_width)) u_addr_mux (
    .select(sel_d), .in0(i_address), .in1(d_address), .out(pmem_address)
  );
  twomux #(.width(line_width)) u_wdata_mux (
    .select(sel_d), .in0('0), .in1(d_wdata), .out(pmem_wdata)
  );
  assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed checks of grant, forwarding, routing and reset
module tb_cache_mem_arbiter;
  logic         clk = 0;
  logic         rst, i_read, d_read, d_write, pmem_resp;
  logic [31:0]  i_address, d_address;
  logic [255:0] d_wdata, pmem_rdata;
  logic         i_resp, d_resp, pmem_read, pmem_write;
  logic [255:0] i_rdata, d_rdata, pmem_wdata;
  logic [31:0]  pmem_address;
  int checks = 0, errors = 0;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
    step(); step(); settle();
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL reset_pmem_read got %b want 0", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL reset_pmem_write got %b want 0", pmem_write); end
    checks++; if ({i_resp, d_resp} !== 2'b00) begin errors++; $display("FAIL reset_resps got %b want 00", {i_resp, d_resp}); end
    step(); rst = 0; settle();
    checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL post_reset_strobes got %b want 00", {pmem_read, pmem_write}); end
  endtask

  task automatic test_i_read();
    step(); i_read = 1; i_address = 32'h0000_2000; settle();
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL i_c0_read got %b want 0", pmem_read); end
    for (int c = 1; c <= 2; c++) begin
      step(); settle();
      checks++; if ({pmem_read, pmem_write} !== 2'b10) begin errors++; $display("FAIL i_c%0d_strobes got %b want 10", c, {pmem_read, pmem_write}); end
      checks++; if (pmem_address !== 32'h0000_2000) begin errors++; $display("FAIL i_c%0d_addr got %h want 00002000", c, pmem_address); end
      checks++; if (i_resp !== 1'b0) begin errors++; $display("FAIL i_c%0d_early_resp got %b want 0", c, i_resp); end
    end
    step(); pmem_resp = 1; pmem_rdata = {8{32'h1234_5678}}; settle();
    checks++; if ({i_resp, d_resp, pmem_read} !== 3'b101) begin errors++; $display("FAIL i_c3_resp got %b want 101", {i_resp, d_resp, pmem_read}); end
    checks++; if (i_rdata !== {8{32'h1234_5678}}) begin errors++; $display("FAIL i_rdata got %h want %h", i_rdata, {8{32'h1234_5678}}); end
    step(); i_read = 0; pmem_resp = 0; settle();
    checks++; if ({pmem_read, i_resp} !== 2'b00) begin errors++; $display("FAIL i_c4_idle got %b want 00", {pmem_read, i_resp}); end
  endtask

  task automatic test_d_write();
    step(); d_write = 1; d_address = 32'h0000_1040; d_wdata = {8{32'hDEAD_BEEF}}; settle();
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL d_c0_write got %b want 0", pmem_write); end
    step(); settle();
    checks++; if ({pmem_read, pmem_write} !== 2'b01) begin errors++; $display("FAIL d_c1_strobes got %b want 01", {pmem_read, pmem_write}); end
    checks++; if (pmem_address !== 32'h0000_1040) begin errors++; $display("FAIL d_c1_addr got %h want 00001040", pmem_address); end
    checks++; if (pmem_wdata !== {8{32'hDEAD_BEEF}}) begin errors++; $display("FAIL d_c1_wdata got %h want %h", pmem_wdata, {8{32'hDEAD_BEEF}}); end
    checks++; if (d_resp !== 1'b0) begin errors++; $display("FAIL d_c1_early_resp got %b want 0", d_resp); end
    step(); pmem_resp = 1; settle();
    checks++; if ({i_resp, d_resp} !== 2'b01) begin errors++; $display("FAIL d_c2_resp got %b want 01", {i_resp, d_resp}); end
    step(); d_write = 0; pmem_resp = 0; settle();
    checks++; if ({pmem_write, d_resp} !== 2'b00) begin errors++; $display("FAIL d_c3_idle got %b want 00", {pmem_write, d_resp}); end
  endtask

  task automatic test_tie();
    // last grant was D, so round-robin hands every round's tie to I
`ifdef ARB_ROUND_ROBIN_EN
    logic first_d = 1'b0;
`else
    logic first_d = 1'b1;
`endif
    for (int r = 0; r < 4; r++) begin
      step(); i_read = 1; i_address = 32'h0000_3000 + r; d_write = 1; d_address = 32'h0000_4000 + r; settle();
      step(); pmem_resp = 1; settle();
      checks++; if ({pmem_read, pmem_write} !== (first_d ? 2'b01 : 2'b10)) begin errors++; $display("FAIL tie%0d_first_strobes got %b want %b", r, {pmem_read, pmem_write}, first_d ? 2'b01 : 2'b10); end
      checks++; if ({i_resp, d_resp} !== (first_d ? 2'b01 : 2'b10)) begin errors++; $display("FAIL tie%0d_first_resp got %b want %b", r, {i_resp, d_resp}, first_d ? 2'b01 : 2'b10); end
      step(); pmem_resp = 0; if (first_d) d_write = 0; else i_read = 0; settle();
      checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL tie%0d_gap got %b want 00", r, {pmem_read, pmem_write}); end
      step(); pmem_resp = 1; settle();
      checks++; if (pmem_address !== (first_d ? 32'h0000_3000 + r : 32'h0000_4000 + r)) begin errors++; $display("FAIL tie%0d_second_addr got %h", r, pmem_address); end
      checks++; if ({i_resp, d_resp} !== (first_d ? 2'b10 : 2'b01)) begin errors++; $display("FAIL tie%0d_second_resp got %b want %b", r, {i_resp, d_resp}, first_d ? 2'b10 : 2'b01); end
      step(); pmem_resp = 0; i_read = 0; d_write = 0; settle();
    end
  endtask

  task automatic test_back_to_back();
    step(); d_read = 1; d_address = 32'h0000_5000; settle();
    step(); i_read = 1; i_address = 32'h0000_6000; settle();
    checks++; if ({pmem_read, pmem_write, pmem_address} !== {2'b10, 32'h0000_5000}) begin errors++; $display("FAIL b2b_d_read got %b %b %h", pmem_read, pmem_write, pmem_address); end
    step(); pmem_resp = 1; settle();
    checks++; if ({i_resp, d_resp} !== 2'b01) begin errors++; $display("FAIL b2b_d_resp got %b want 01", {i_resp, d_resp}); end
    step(); pmem_resp = 0; d_read = 0; settle();
    checks++; if ({pmem_read, i_resp, d_resp} !== 3'b000) begin errors++; $display("FAIL b2b_idle got %b want 000", {pmem_read, i_resp, d_resp}); end
    step(); settle();
    checks++; if ({pmem_read, pmem_address} !== {1'b1, 32'h0000_6000}) begin errors++; $display("FAIL b2b_i_grant got %b %h", pmem_read, pmem_address); end
    pmem_resp = 1; settle();
    checks++; if ({i_resp, d_resp} !== 2'b10) begin errors++; $display("FAIL b2b_i_resp got %b want 10", {i_resp, d_resp}); end
    step(); pmem_resp = 0; i_read = 0; settle();
  endtask

  task automatic test_reset_mid();
    step(); d_write = 1; d_address = 32'h0000_7000; settle();
    step(); settle();
    checks++; if (pmem_write !== 1'b1) begin errors++; $display("FAIL rm_serve got %b want 1", pmem_write); end
    step(); rst = 1; settle();
    step(); rst = 0; d_write = 0; settle();
    checks++; if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin errors++; $display("FAIL rm_idle got %b want 0000", {pmem_read, pmem_write, i_resp, d_resp}); end
    pmem_resp = 1; settle();
    checks++; if ({i_resp, d_resp} !== 2'b00) begin errors++; $display("FAIL rm_stray_resp got %b want 00", {i_resp, d_resp}); end
    step(); pmem_resp = 0; settle();
    checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL rm_stay_idle got %b want 00", {pmem_read, pmem_write}); end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
